pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32 core. It watches the decode stage's register-read requests and the ID/EX, EX and MEM stage state. It drives per-stage hold (stall) and bubble (flush) controls plus the PC redirect. It covers three cases:
- load-use hazards, which operand forwarding cannot resolve;
- taken branches and jumps;
- multi-cycle data-memory waits, with a watchdog timeout.

## Interface
Parameters:
- FLUSH_CYCLES, 1: number of cycles flush_o stays 2'b11 after a taken branch. Legal range 1..7.
- MEM_TIMEOUT, 255: number of consecutive MEM_WAIT cycles before err_o sets. Legal range 1..65535.

Ports (one clock; reset is asynchronous, active-low):
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_reg1_read_i  in  1  decode reads rs1
- id_reg2_read_i  in  1  decode reads rs2
- id_reg1_addr_i  in  5  rs1 address
- id_reg2_addr_i  in  5  rs2 address
- ex_aluop_i  in  7  opcode of the instruction in EX
- ex_wd_i  in  5  destination register of the instruction in EX
- ex_wreg_i  in  1  EX instruction writes a register
- ex_branch_taken_i  in  1  EX resolved a taken branch or jal
- ex_branch_target_i  in  32  target of that branch
- mem_stall_req_i  in  1  data memory not ready
- stall_o  out  5  hold enables: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB
- flush_o  out  2  bubble inserts: [0] IF/ID, [1] ID/EX
- pc_redirect_o  out  1  load pc_target_o into PC
- pc_target_o  out  32  redirect address
- err_o  out  1  sticky memory-timeout flag
- state_o  out  2  FSM state, for debug

## Operation
FSM states:
- RUN = 0
- FLUSH = 1
- MEM_WAIT = 2

Load-use hazard (luse) is true when all of the following hold:
- ex_aluop_i == OP_LOAD (7'b0000011), and ex_wreg_i == 1, and ex_wd_i != 0;
- and (id_reg1_read_i && id_reg1_addr_i == ex_wd_i) or (id_reg2_read_i && id_reg2_addr_i == ex_wd_i).

Event priority within a cycle: mem_stall_req_i > ex_branch_taken_i > luse.

RUN state (outputs are Mealy, combinational in the same cycle):
- mem_stall_req_i:
  - stall_o = 5'b01111, flush_o = 0.
  - Next state MEM_WAIT; timeout counter cleared to 1.
- Branch taken:
  - pc_redirect_o = 1, pc_target_o = ex_branch_target_i, flush_o = 2'b11, stall_o = 0.
  - If FLUSH_CYCLES > 1: next state FLUSH, with the flush counter loaded to FLUSH_CYCLES-1.
- luse:
  - stall_o = 5'b00011, flush_o = 2'b10, giving exactly one bubble.
  - Stays in RUN; the next cycle re-evaluates normally (the load is then in MEM and forwarding covers it).
- Otherwise all controls are 0.

FLUSH state:
- flush_o = 2'b11; the counter decrements each cycle; return to RUN when the counter reaches 1.
- mem_stall_req_i overrides: go to MEM_WAIT and abandon the remaining flush count.
- Branch and luse are ignored.

MEM_WAIT state:
- stall_o = 5'b01111; branch and luse are ignored because EX is frozen and re-evaluated afterwards.
- The 16-bit timeout counter increments and saturates.
- When the counter reaches MEM_TIMEOUT, err_o is set; it clears only on reset.
- When mem_stall_req_i drops, go to RUN that same cycle: outputs are evaluated as in RUN using current inputs.

pc_target_o is 0 whenever pc_redirect_o is 0.

## Timing
- Reset values (asynchronous assert, synchronous release):
  - state = RUN;
  - stall_o = 0, flush_o = 0, pc_redirect_o = 0, pc_target_o = 0;
  - err_o = 0, state_o = 0;
  - all counters = 0.
- Hazard, branch and stall controls have zero latency: they are combinational from inputs and state in the same cycle.
- The state, counters and err_o update on the rising clk edge.
- A load-use bubble costs exactly 1 cycle.
- A taken branch costs FLUSH_CYCLES flush cycles.
- A memory wait of N cycles holds the pipeline for exactly N cycles.
- Reset mid-FLUSH or mid-MEM_WAIT aborts immediately; no residual flush or stall appears after release.
- A mem stall arriving on the last FLUSH cycle takes precedence; the flush is not extended afterwards.

## Configuration
- PIPE_HAZARD_PERF_EN defined:
  - adds output ports perf_stall_cnt_o[31:0], perf_flush_cnt_o[31:0] and perf_luse_cnt_o[15:0];
  - these count cycles with stall_o[0] high, cycles with flush_o != 0, and luse events respectively;
  - the counters wrap modulo their width and reset to 0.
- PIPE_HAZARD_PERF_EN not defined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package pipe_pkg holds:
  - opcode constants OP_LOAD, OP_BRANCH, OP_JAL;
  - the state enum (RUN/FLUSH/MEM_WAIT);
  - stall-bit index constants STL_PC..STL_WB and flush-bit constants FL_IFID/FL_IDEX.
- One sub-module, pipe_perf_cnt: the perf counter bank, instantiated only under PIPE_HAZARD_PERF_EN.

## Test plan
- Load-use: ex_aluop_i = 7'b0000011, ex_wd_i = 5, ex_wreg_i = 1, id_reg2_read_i = 1, id_reg2_addr_i = 5 -> stall_o = 5'b00011 and flush_o = 2'b10 for exactly 1 cycle. Repeat with ex_wd_i = 0 -> no stall.
- Branch: ex_branch_taken_i = 1, target 32'h0000_0040, FLUSH_CYCLES = 3 -> pc_redirect_o = 1 with pc_target_o = 0x40 for 1 cycle; flush_o = 2'b11 for 3 cycles; state_o sequence 0,1,1,0.
- Mem wait: mem_stall_req_i high for 4 cycles -> stall_o = 5'b01111 for 4 cycles; a branch asserted during the wait gives no redirect until the wait ends.
- Simultaneous: branch and luse in the same cycle -> redirect and flush_o = 2'b11 only, no stall.
- Timeout: MEM_TIMEOUT = 8, req held 20 cycles -> err_o rises on the 8th wait cycle and stays high after req drops until rst_n = 0.
- Reset mid-FLUSH (FLUSH_CYCLES = 5, rst_n low at cycle 2) -> all outputs 0 immediately, state_o = 0 after release. Under PIPE_HAZARD_PERF_EN, the perf counters are 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared opcodes, FSM state type and stall/flush bit positions for the hazard controller
package pipe_pkg;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MEM_WAIT = 2'd2} state_e;
  localparam int STL_PC = 0;
  localparam int STL_IFID = 1;
  localparam int STL_IDEX = 2;
  localparam int STL_EXMEM = 3;
  localparam int STL_WB = 4;
  localparam int FL_IFID = 0;
  localparam int FL_IDEX = 1;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: decode/EX/MEM hazard inputs and stall/flush/redirect/err/state controls; master = pipeline, slave = controller
interface pipe_hazard_ctrl_if;
  logic        id_reg1_read_i;
  logic        id_reg2_read_i;
  logic [4:0]  id_reg1_addr_i;
  logic [4:0]  id_reg2_addr_i;
  logic [6:0]  ex_aluop_i;
  logic [4:0]  ex_wd_i;
  logic        ex_wreg_i;
  logic        ex_branch_taken_i;
  logic [31:0] ex_branch_target_i;
  logic        mem_stall_req_i;
  logic [4:0]  stall_o;
  logic [1:0]  flush_o;
  logic        pc_redirect_o;
  logic [31:0] pc_target_o;
  logic        err_o;
  logic [1:0]  state_o;
  modport master (
    output id_reg1_read_i, id_reg2_read_i, id_reg1_addr_i, id_reg2_addr_i, ex_aluop_i, ex_wd_i, ex_wreg_i,
           ex_branch_taken_i, ex_branch_target_i, mem_stall_req_i,
    input  stall_o, flush_o, pc_redirect_o, pc_target_o, err_o, state_o
  );
  modport slave (
    input  id_reg1_read_i, id_reg2_read_i, id_reg1_addr_i, id_reg2_addr_i, ex_aluop_i, ex_wd_i, ex_wreg_i,
           ex_branch_taken_i, ex_branch_target_i, mem_stall_req_i,
    output stall_o, flush_o, pc_redirect_o, pc_target_o, err_o, state_o
  );
endinterface

// File: rtl/pipe_perf_cnt.sv
// pipe_perf_cnt: wrapping counters of PC-stall cycles, flush cycles and load-use bubbles; ports clk, rst_n, event inputs, *_cnt_o
module pipe_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_pc_i,
  input  logic        flush_i,
  input  logic        luse_i,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [15:0] luse_cnt_o
);
  logic [31:0] stall_q, flush_q;
  logic [15:0] luse_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
      luse_q <= '0;
    end else begin
      stall_q <= stall_q + 32'(stall_pc_i);
      flush_q <= flush_q + 32'(flush_i);
      luse_q <= luse_q + 16'(luse_i);
    end
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;
  assign luse_cnt_o = luse_q;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use/branch/mem-wait hazard controller; ports clk, rst_n, hz (slave modport), perf_*_cnt_o only when PIPE_HAZARD_PERF_EN is defined
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input logic clk,
  input logic rst_n,
  pipe_hazard_ctrl_if.slave hz
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_flush_cnt_o,
  output logic [15:0] perf_luse_cnt_o
`endif
);
  state_e state_q, state_d;
  logic [2:0] fcnt_q, fcnt_d;
  logic [15:0] tcnt_q, tcnt_d;
  logic err_q, err_d;
  logic [4:0] stall;
  logic [1:0] flush;
  logic redirect;
  logic [31:0] target;
  logic luse;
  assign luse = hz.ex_aluop_i == OP_LOAD && hz.ex_wreg_i && hz.ex_wd_i != 5'd0 &&
                ((hz.id_reg1_read_i && hz.id_reg1_addr_i == hz.ex_wd_i) ||
                 (hz.id_reg2_read_i && hz.id_reg2_addr_i == hz.ex_wd_i));
  // A MEM_WAIT cycle whose request has dropped is treated as RUN so the frozen EX instruction is re-evaluated at once.
  always_comb begin
    state_d = state_q;
    fcnt_d = fcnt_q;
    tcnt_d = tcnt_q;
    stall = '0;
    flush = '0;
    redirect = 1'b0;
    target = '0;
    if (hz.mem_stall_req_i) begin
      stall[STL_EXMEM:STL_PC] = '1;
      state_d = MEM_WAIT;
      fcnt_d = '0;
      tcnt_d = state_q != MEM_WAIT ? 16'd1 : &tcnt_q ? tcnt_q : tcnt_q + 16'd1;
    end else if (state_q == FLUSH) begin
      flush = '1;
      fcnt_d = fcnt_q - 3'd1;
      state_d = fcnt_q == 3'd1 ? RUN : FLUSH;
    end else begin
      state_d = RUN;
      tcnt_d = '0;
      if (hz.ex_branch_taken_i) begin
        redirect = 1'b1;
        target = hz.ex_branch_target_i;
        flush = '1;
        state_d = FLUSH_CYCLES > 1 ? FLUSH : RUN;
        fcnt_d = 3'(FLUSH_CYCLES - 1);
      end else if (luse) begin
        stall[STL_IFID:STL_PC] = '1;
        flush[FL_IDEX] = 1'b1;
      end
    end
    err_d = err_q | (hz.mem_stall_req_i && tcnt_d >= 16'(MEM_TIMEOUT));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= RUN;
      fcnt_q <= '0;
      tcnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q <= fcnt_d;
      tcnt_q <= tcnt_d;
      err_q <= err_d;
    end
  // Held low while reset is asserted so no control leaks from live inputs.
  assign hz.stall_o = rst_n ? stall : '0;
  assign hz.flush_o = rst_n ? flush : '0;
  assign hz.pc_redirect_o = rst_n & redirect;
  assign hz.pc_target_o = rst_n ? target : '0;
  assign hz.err_o = err_q;
  assign hz.state_o = state_q;
`ifdef PIPE_HAZARD_PERF_EN
  pipe_perf_cnt u_perf (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall_pc_i  (stall[STL_PC]),
    .flush_i     (|flush),
    .luse_i      (flush == 2'b10),
    .stall_cnt_o (perf_stall_cnt_o),
    .flush_cnt_o (perf_flush_cnt_o),
    .luse_cnt_o  (perf_luse_cnt_o)
  );
`endif
endmodule
